// File: rtl/fwd_hazard_pkg.sv
// Shared definitions for the forwarding / hazard unit.
//   - Opcode encodings of the 16-bit ID instruction.
//   - Bit positions of the opcode and register fields.
//   - Scoreboard entry type: one in-flight destination per pipeline slot.
// Build option: HAZ_R0_ZERO_EN (see fwd_instr_decode) makes r0 a hardwired zero.
package fwd_hazard_pkg;

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_SLTI = 4'd3;
  localparam logic [3:0] OP_LW   = 4'd4;
  localparam logic [3:0] OP_SW   = 4'd5;
  localparam logic [3:0] OP_BEQ  = 4'd6;

  // Instruction layout: [15:12] opcode, [11:9] rs, [8:6] rt, [5:3] rd, [2:0] spare.
  localparam int INSTR_W = 16;
  localparam int OPC_LSB = 12;
  localparam int OPC_W   = 4;
  localparam int RS_LSB  = 9;
  localparam int RT_LSB  = 6;
  localparam int RD_LSB  = 3;
  localparam int FIELD_W = 3;

  // Destination storage is sized for the widest supported register file
  // (REG_AW <= 8); narrower addresses are zero-extended on entry and compare.
  localparam int SB_DEST_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [SB_DEST_W-1:0] dest;
    logic                 is_load;
  } sb_entry_t;

endpackage

// File: rtl/fwd_instr_decode.sv
// Combinational decode of the ID-stage instruction into the register
// operands the forwarding logic cares about.
//   instr                  : 16-bit ID instruction
//   src_a / src_b / src_sw : operand A, operand B and store-data register
//   a_used / b_used / sw_used : the opcode actually reads that operand
//   dest / dest_valid      : destination register and whether one is written
//   is_load                : instruction is a load (result arrives late)
// Build option: `define HAZ_R0_ZERO_EN to treat r0 as a hardwired zero --
// it is then never a source that needs forwarding and never a destination.
module fwd_instr_decode
  import fwd_hazard_pkg::*;
#(
  parameter int REG_AW = 3
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [REG_AW-1:0]  src_a,
  output logic [REG_AW-1:0]  src_b,
  output logic [REG_AW-1:0]  src_sw,
  output logic               a_used,
  output logic               b_used,
  output logic               sw_used,
  output logic [REG_AW-1:0]  dest,
  output logic               dest_valid,
  output logic               is_load
);

  logic [OPC_W-1:0]  opcode;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic              unused_spare;

  // Register fields occupy the low bits of the address; wider register
  // files see them zero-extended.
  assign opcode       = instr[OPC_LSB +: OPC_W];
  assign rs           = REG_AW'(instr[RS_LSB +: FIELD_W]);
  assign rt           = REG_AW'(instr[RT_LSB +: FIELD_W]);
  assign rd           = REG_AW'(instr[RD_LSB +: FIELD_W]);
  assign unused_spare = ^instr[RD_LSB-1:0];

  always_comb begin
    // NOTE: every output gets a default before the case so that opcodes
    // which do not touch a signal cannot infer a latch.
    src_a      = rs;
    src_b      = rt;
    src_sw     = rt;
    a_used     = 1'b0;
    b_used     = 1'b0;
    sw_used    = 1'b0;
    dest       = '0;
    dest_valid = 1'b0;
    is_load    = 1'b0;

    case (opcode)
      OP_R: begin
        a_used     = 1'b1;
        b_used     = 1'b1;
        dest       = rd;
        dest_valid = 1'b1;
      end
      OP_ADDI, OP_SLTI: begin
        b_used     = 1'b1;
        dest       = rs;
        dest_valid = 1'b1;
      end
      OP_LW: begin
        a_used     = 1'b1;
        dest       = rt;
        dest_valid = 1'b1;
        is_load    = 1'b1;
      end
      OP_SW: begin
        a_used  = 1'b1;
        sw_used = 1'b1;
      end
      OP_BEQ: begin
        a_used = 1'b1;
        b_used = 1'b1;
      end
      default: ;
    endcase

`ifdef HAZ_R0_ZERO_EN
    if (src_a == '0)  a_used     = 1'b0;
    if (src_b == '0)  b_used     = 1'b0;
    if (src_sw == '0) sw_used    = 1'b0;
    if (dest == '0)   dest_valid = 1'b0;
`else
`endif
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit beside the ID/EX boundary.
// Tracks FWD_DEPTH in-flight destinations (slot 1 = EX output, slot
// FWD_DEPTH = oldest) and registers, for the instruction entering EX, which
// slot result each operand should be taken from (0 = register file).
//   clk, rst       : clock, synchronous active-high reset
//   id_valid       : ID instruction valid
//   id_instr       : ID instruction
//   flush_i        : branch taken, kill the ID instruction
//   stage_res_i    : slot k result at [k*DATA_W-1 -: DATA_W]
//   fwd_sel_a/b/sw : registered forwarding selects
//   fwd_*_data     : selected slot result (0 when select is 0)
//   stall_o        : load-use stall, hold PC/IF/ID and bubble EX
// Build option: `define HAZ_R0_ZERO_EN for a hardwired-zero r0.
module fwd_hazard_unit
  import fwd_hazard_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int REG_AW    = 3,
  parameter int FWD_DEPTH = 2,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [INSTR_W-1:0]          id_instr,
  input  logic                        flush_i,
  input  logic [FWD_DEPTH*DATA_W-1:0] stage_res_i,
  output logic [SEL_W-1:0]            fwd_sel_a,
  output logic [SEL_W-1:0]            fwd_sel_b,
  output logic [SEL_W-1:0]            fwd_sel_sw,
  output logic [DATA_W-1:0]           fwd_a_data,
  output logic [DATA_W-1:0]           fwd_b_data,
  output logic [DATA_W-1:0]           fwd_sw_data,
  output logic                        stall_o
);

  // A store whose data register is produced by a load just ahead of it does
  // not stall: the data is only needed one stage later, when the load sits
  // in slot 2. With a single tracked slot there is no slot 2, so that case
  // stalls like any other load-use.
  localparam bit SW_DEFER = (FWD_DEPTH >= 2);

  logic [REG_AW-1:0] src_a, src_b, src_sw, dest;
  logic              a_used, b_used, sw_used, dest_valid, is_load;

  sb_entry_t         sb [FWD_DEPTH];
  sb_entry_t         new_entry;
  logic [SEL_W-1:0]  match_a, match_b, match_sw;
  logic [SEL_W-1:0]  next_sel_a, next_sel_b, next_sel_sw;
  logic              hit_a, hit_b, hit_sw;
  logic              issue;

  fwd_instr_decode #(
    .REG_AW (REG_AW)
  ) u_decode (
    .instr      (id_instr),
    .src_a      (src_a),
    .src_b      (src_b),
    .src_sw     (src_sw),
    .a_used     (a_used),
    .b_used     (b_used),
    .sw_used    (sw_used),
    .dest       (dest),
    .dest_valid (dest_valid),
    .is_load    (is_load)
  );

  // Youngest match wins: scan oldest to youngest so the last hit is the
  // smallest slot number.
  always_comb begin
    match_a  = '0;
    match_b  = '0;
    match_sw = '0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (sb[k].valid && sb[k].dest == SB_DEST_W'(src_a))  match_a  = SEL_W'(k + 1);
      if (sb[k].valid && sb[k].dest == SB_DEST_W'(src_b))  match_b  = SEL_W'(k + 1);
      if (sb[k].valid && sb[k].dest == SB_DEST_W'(src_sw)) match_sw = SEL_W'(k + 1);
    end
  end

  // Load-use against the instruction currently in EX (slot 1).
  always_comb begin
    hit_a  = a_used  && sb[0].dest == SB_DEST_W'(src_a);
    hit_b  = b_used  && sb[0].dest == SB_DEST_W'(src_b);
    hit_sw = sw_used && sb[0].dest == SB_DEST_W'(src_sw) && !SW_DEFER;
    stall_o = id_valid && !flush_i && sb[0].valid && sb[0].is_load
              && (hit_a || hit_b || hit_sw);
  end

  // Only an instruction that really advances into EX carries selects; a
  // stall or flush bubble presents all-zero selects.
  assign issue = id_valid && !stall_o && !flush_i;

  always_comb begin
    next_sel_a  = (issue && a_used) ? match_a : '0;
    next_sel_b  = (issue && b_used) ? match_b : '0;
    next_sel_sw = '0;
    if (issue && sw_used) begin
      if (SW_DEFER && match_sw == SEL_W'(1) && sb[0].is_load) next_sel_sw = SEL_W'(2);
      else                                                    next_sel_sw = match_sw;
    end

    new_entry.valid   = issue && dest_valid;
    new_entry.dest    = SB_DEST_W'(dest);
    new_entry.is_load = is_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the scoreboard is a handful of flops whose valid bits drive
      // forwarding and stalls, so every slot is cleared on reset rather than
      // left to be flushed out by bubbles.
      for (int k = 0; k < FWD_DEPTH; k++) sb[k] <= '0;
      fwd_sel_a  <= '0;
      fwd_sel_b  <= '0;
      fwd_sel_sw <= '0;
    end else begin
      // NOTE: non-blocking assignments let the shift read every slot's old
      // value in the same edge, independent of statement order.
      sb[0] <= new_entry;
      for (int k = 1; k < FWD_DEPTH; k++) sb[k] <= sb[k-1];
      fwd_sel_a  <= next_sel_a;
      fwd_sel_b  <= next_sel_b;
      fwd_sel_sw <= next_sel_sw;
    end
  end

  // Data mux over the live stage results using the registered selects.
  always_comb begin
    fwd_a_data  = '0;
    fwd_b_data  = '0;
    fwd_sw_data = '0;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      if (fwd_sel_a  == SEL_W'(k + 1)) fwd_a_data  = stage_res_i[k*DATA_W +: DATA_W];
      if (fwd_sel_b  == SEL_W'(k + 1)) fwd_b_data  = stage_res_i[k*DATA_W +: DATA_W];
      if (fwd_sel_sw == SEL_W'(k + 1)) fwd_sw_data = stage_res_i[k*DATA_W +: DATA_W];
    end
  end

endmodule
